// File: rtl/add_join_stage_pkg.sv
// Shared constants and helpers for the add/join pipeline stage.
// Operand and result width live here so every file agrees on it.
package add_join_stage_pkg;

    localparam int DATA_WIDTH = 32;

    // Unsigned sum modulo 2^DATA_WIDTH; the carry-out is dropped on purpose.
    function automatic logic [DATA_WIDTH-1:0] add_mod(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        add_mod = a + b;
    endfunction

endpackage

// File: rtl/add_join_stage_plain_stage.sv
// One-entry valid/data register slice with the codebase's valid/stall handshake.
// The slot reloads whenever it is empty or being taken downstream.
module plain_stage
    import add_join_stage_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             v_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             stall_o,
    output logic             v_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             stall_i
);

    logic             v_r;
    logic [WIDTH-1:0] data_r;
    logic             hold_s;

    assign hold_s  = v_r & stall_i;
    assign stall_o = hold_s;
    assign v_o     = v_r;
    assign data_o  = data_r;

    // Slot register: held while occupied and stalled, otherwise follows the input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_r    <= 1'b0;
            data_r <= {WIDTH{1'b0}};
        end else if (!hold_s) begin
            v_r <= v_i;
            if (v_i) begin
                data_r <= data_i;
            end
        end
    end

endmodule

// File: rtl/add_join_stage.sv
// Two-input join stage: waits for both operands, then registers their sum.
// A lone operand is stalled until its partner shows up, so operands pair in order.
module add_join_stage
    import add_join_stage_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             v_i1,
    input  logic [WIDTH-1:0] data_i1,
    input  logic             v_i2,
    input  logic [WIDTH-1:0] data_i2,
    output logic             stall_o1,
    output logic             stall_o2,
    output logic             v_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             stall_i
);

    logic             pair_v_s;
    logic [WIDTH-1:0] sum_s;
    logic             hold_s;

    assign pair_v_s = v_i1 & v_i2;
    assign sum_s    = data_i1 + data_i2;

    // Back-pressure: downstream hold, or an operand still waiting for its partner.
    always_comb begin
        stall_o1 = 1'b0;
        stall_o2 = 1'b0;
        if (hold_s) begin
            stall_o1 = 1'b1;
            stall_o2 = 1'b1;
        end else begin
            stall_o1 = v_i1 & ~v_i2;
            stall_o2 = v_i2 & ~v_i1;
        end
    end

    plain_stage #(
        .WIDTH (WIDTH)
    ) u_out_stage (
        .clk     (clk),
        .reset   (reset),
        .v_i     (pair_v_s),
        .data_i  (sum_s),
        .stall_o (hold_s),
        .v_o     (v_o),
        .data_o  (data_o),
        .stall_i (stall_i)
    );

endmodule

// File: tb/tb_add_join_stage.sv
// Directed self-checking bench for add_join_stage.
// Inputs change #1 after the rising edge; outputs are sampled before the next edge.
module tb_add_join_stage;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         v_i1;
    logic [W-1:0] data_i1;
    logic         v_i2;
    logic [W-1:0] data_i2;
    logic         stall_o1;
    logic         stall_o2;
    logic         v_o;
    logic [W-1:0] data_o;
    logic         stall_i;

    int n_checks = 0;
    int n_fail   = 0;

    add_join_stage #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .v_i1     (v_i1),
        .data_i1  (data_i1),
        .v_i2     (v_i2),
        .data_i2  (data_i2),
        .stall_o1 (stall_o1),
        .stall_o2 (stall_o2),
        .v_o      (v_o),
        .data_o   (data_o),
        .stall_i  (stall_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a_v, input logic [W-1:0] a_d,
                         input logic b_v, input logic [W-1:0] b_d, input logic st);
        v_i1    = a_v;
        data_i1 = a_d;
        v_i2    = b_v;
        data_i2 = b_d;
        stall_i = st;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);

        // 1. reset with toggling inputs
        for (int i = 0; i < 4; i++) begin
            drive(i[0], 32'h1234 + 32'(i), i[0], 32'h55 + 32'(i), 1'b0);
            check_eq("rst_stall_o1", {31'd0, stall_o1}, 32'd0);
            check_eq("rst_stall_o2", {31'd0, stall_o2}, 32'd0);
            step();
            check_eq("rst_v_o", {31'd0, v_o}, 32'd0);
            check_eq("rst_data_o", data_o, 32'd0);
        end
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        reset = 1'b1;
        step();
        check_eq("idle_v_o", {31'd0, v_o}, 32'd0);
        check_eq("idle_stall_o1", {31'd0, stall_o1}, 32'd0);

        // 2. both valid
        drive(1'b1, 32'hf, 1'b1, 32'hf, 1'b0);
        check_eq("pair_stall_o1", {31'd0, stall_o1}, 32'd0);
        check_eq("pair_stall_o2", {31'd0, stall_o2}, 32'd0);
        step();
        check_eq("pair_v_o", {31'd0, v_o}, 32'd1);
        check_eq("pair_data_o", data_o, 32'h1e);

        // 3. lone operand 1, partner arrives a cycle later
        drive(1'b1, 32'd100, 1'b0, 32'd0, 1'b0);
        check_eq("lone1_stall_o1", {31'd0, stall_o1}, 32'd1);
        check_eq("lone1_stall_o2", {31'd0, stall_o2}, 32'd0);
        step();
        check_eq("lone1_v_o", {31'd0, v_o}, 32'd0);
        check_eq("lone1_data_kept", data_o, 32'h1e);
        drive(1'b1, 32'd100, 1'b1, 32'd10, 1'b0);
        check_eq("join_stall_o1", {31'd0, stall_o1}, 32'd0);
        step();
        check_eq("join_v_o", {31'd0, v_o}, 32'd1);
        check_eq("join_data_o", data_o, 32'd110);

        // lone operand 2
        drive(1'b0, 32'd0, 1'b1, 32'd3, 1'b0);
        check_eq("lone2_stall_o1", {31'd0, stall_o1}, 32'd0);
        check_eq("lone2_stall_o2", {31'd0, stall_o2}, 32'd1);

        // 4. downstream stall while occupied
        drive(1'b1, 32'd10, 1'b1, 32'd20, 1'b0);
        step();
        check_eq("pre_stall_data_o", data_o, 32'd30);
        drive(1'b1, 32'd5, 1'b1, 32'd6, 1'b1);
        check_eq("hold_stall_o1", {31'd0, stall_o1}, 32'd1);
        check_eq("hold_stall_o2", {31'd0, stall_o2}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("hold_data_o", data_o, 32'd30);
            check_eq("hold_v_o", {31'd0, v_o}, 32'd1);
        end
        drive(1'b1, 32'd5, 1'b1, 32'd6, 1'b0);
        check_eq("release_stall_o1", {31'd0, stall_o1}, 32'd0);
        step();
        check_eq("release_data_o", data_o, 32'd11);

        // 5. bubble fill with stall_i asserted
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        step();
        check_eq("bubble_v_o", {31'd0, v_o}, 32'd0);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        check_eq("invalid_stall_o1", {31'd0, stall_o1}, 32'd0);
        check_eq("invalid_stall_o2", {31'd0, stall_o2}, 32'd0);
        drive(1'b1, 32'd7, 1'b1, 32'd8, 1'b1);
        check_eq("fill_stall_o1", {31'd0, stall_o1}, 32'd0);
        check_eq("fill_stall_o2", {31'd0, stall_o2}, 32'd0);
        step();
        check_eq("fill_v_o", {31'd0, v_o}, 32'd1);
        check_eq("fill_data_o", data_o, 32'd15);

        // 6. modulo wrap, then async reset mid-cycle
        drive(1'b1, 32'hFFFF_FFFF, 1'b1, 32'h2, 1'b0);
        step();
        check_eq("wrap_data_o", data_o, 32'h1);
        check_eq("wrap_v_o", {31'd0, v_o}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_rst_v_o", {31'd0, v_o}, 32'd0);
        check_eq("async_rst_data_o", data_o, 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
